// File: rtl/raspi_pkg.sv
// Shared constants and payload types for the Raspberry Pi 9-bit parallel bus endpoint.
package raspi_pkg;

  localparam int unsigned RASPI_W = 9;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [RASPI_W-1:0] CTRL_START    = 9'h101;
  localparam logic [RASPI_W-1:0] CTRL_END      = 9'h100;
  localparam logic [RASPI_W-1:0] TX_EMPTY_WORD = 9'h000;

  // Received bus word: ctrl marks start/end markers, data carries the byte.
  typedef struct packed {
    logic              ctrl;
    logic [BYTE_W-1:0] data;
  } raspi_word_t;

endpackage

// File: rtl/raspi_tx_fifo.sv
// Synchronous FIFO for bytes returned to the host; wrap-bit pointers, registered flags/level.
module raspi_tx_fifo
  import raspi_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     head_c_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              do_push, do_pop;

  // A pop frees the head slot, so a push into a full FIFO is accepted in the same cycle.
  always_comb begin
    do_pop  = pop_i && !empty_q;
    do_push = push_i && (!full_q || do_pop);
    wr_d    = wr_q + PTR_W'(do_push);
    rd_d    = rd_q + PTR_W'(do_pop);
    level_d = wr_d - rd_d;
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[DEPTH_LOG2] != rd_d[DEPTH_LOG2]) &&
              (wr_d[DEPTH_LOG2-1:0] == rd_d[DEPTH_LOG2-1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[DEPTH_LOG2-1:0]] <= data_i;
    end
  end

  assign head_c_o = mem_q[rd_q[DEPTH_LOG2-1:0]];
  assign empty_o  = empty_q;
  assign full_o   = full_q;
  assign level_o  = level_q;

endmodule

// File: rtl/raspi_link.sv
// FPGA endpoint of the Raspberry Pi 9-bit strobe bus: host writes arrive on an RX
// valid/ready stream, host reads are served from a TX byte FIFO.
module raspi_link
  import raspi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned TURN_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RASPI_W-1:0]       raspi_dat_i,
  output logic [RASPI_W-1:0]       raspi_dat_o,
  output logic                     raspi_dat_oe,
  input  logic                     raspi_dir,
  input  logic                     raspi_clk,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [RASPI_W-1:0]       rx_data,
  output logic                     rx_overflow,
  input  logic                     rx_overflow_clr,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [BYTE_W-1:0]        tx_data,
  output logic [TX_DEPTH_LOG2:0]   tx_level
);

  localparam int unsigned TURN_W = $clog2(TURN_CYCLES + 1);

  logic [SYNC_STAGES-1:0]              clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]              dir_sync_q, dir_sync_d;
  logic [SYNC_STAGES-1:0][RASPI_W-1:0] dat_sync_q, dat_sync_d;
  logic                                clk_prev_q, clk_prev_d;
  logic [TURN_W-1:0]                   turn_q, turn_d;
  logic                                rx_valid_q, rx_valid_d;
  raspi_word_t                         rx_word_q, rx_word_d;
  logic                                rx_ovf_q, rx_ovf_d;

  logic               sync_clk, sync_dir;
  logic [RASPI_W-1:0] sync_dat;
  logic               strobe_evt_c;
  logic               oe_c;
  logic               tx_pop_c;
  logic [BYTE_W-1:0]  fifo_head_c;
  logic               fifo_empty, fifo_full;

  assign sync_clk = clk_sync_q[SYNC_STAGES-1];
  assign sync_dir = dir_sync_q[SYNC_STAGES-1];
  assign sync_dat = dat_sync_q[SYNC_STAGES-1];

  // Pad synchronizers and strobe edge detect.
  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], raspi_clk};
    dir_sync_d   = {dir_sync_q[SYNC_STAGES-2:0], raspi_dir};
    dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], raspi_dat_i};
    clk_prev_d   = sync_clk;
    strobe_evt_c = sync_clk && !clk_prev_q;
  end

  // Turnaround: drive only after the host has released the bus for TURN_CYCLES;
  // oe also gates on sync_dir directly so it drops in the cycle the host reclaims the bus.
  always_comb begin
    turn_d = turn_q;
    if (sync_dir) begin
      turn_d = '0;
    end else if (turn_q != TURN_W'(TURN_CYCLES)) begin
      turn_d = turn_q + TURN_W'(1);
    end
    oe_c     = !sync_dir && (turn_q == TURN_W'(TURN_CYCLES));
    tx_pop_c = strobe_evt_c && oe_c;
  end

  // RX holding register with sticky overflow; a same-cycle overflow beats the clear.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_word_d  = rx_word_q;
    rx_ovf_d   = rx_ovf_q;
    if (rx_overflow_clr) begin
      rx_ovf_d = 1'b0;
    end
    if (strobe_evt_c && sync_dir) begin
      if (!rx_valid_q || rx_ready) begin
        rx_word_d  = raspi_word_t'(sync_dat);
        rx_valid_d = 1'b1;
      end else begin
        rx_ovf_d = 1'b1;
      end
    end else if (rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '0;
      dir_sync_q <= '0;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b0;
      turn_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_word_q  <= '0;
      rx_ovf_q   <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dir_sync_q <= dir_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      turn_q     <= turn_d;
      rx_valid_q <= rx_valid_d;
      rx_word_q  <= rx_word_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

  raspi_tx_fifo #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2),
    .DATA_W     (BYTE_W)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (tx_valid),
    .pop_i    (tx_pop_c),
    .data_i   (tx_data),
    .head_c_o (fifo_head_c),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full),
    .level_o  (tx_level)
  );

  // Bit 8 set tells the host the presented byte is real.
  assign raspi_dat_o  = fifo_empty ? TX_EMPTY_WORD : {1'b1, fifo_head_c};
  assign raspi_dat_oe = oe_c;
  assign tx_ready     = !fifo_full;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_word_q;
  assign rx_overflow  = rx_ovf_q;

endmodule

// File: doc/raspi_link.md
Name: raspi_link

Overview:
- FPGA-side endpoint of the 9-bit Raspberry Pi parallel bus: RASPI data[8:0], RASPI_38 = dir, RASPI_40 = strobe clock.
- dir=1 (host writes): receives 9-bit words, delivered on a valid/ready stream. Bit 8 set marks control words: 0x101 = start, 0x100 = end.
- dir=0 (host reads): drives bytes from an internal TX FIFO back onto the bus.
- Instantiated inside c3demo between the RASPI pins and the firmware loader / debug logic.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on raspi_clk, raspi_dir and raspi_dat_i (min 2).
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries).
- TURN_CYCLES, 2, synchronized dir=0 cycles required before raspi_dat_oe asserts.

Ports:
- clk  in  1  system clock (CLK12MHZ domain)
- reset  in  1  asynchronous, active-high reset
- raspi_dat_i  in  9  bus data from pad
- raspi_dat_o  out  9  bus data to pad
- raspi_dat_oe  out  1  pad output enable
- raspi_dir  in  1  1 = host drives bus, 0 = FPGA drives bus
- raspi_clk  in  1  host strobe; rising edge is the event
- rx_valid  out  1  received word available
- rx_ready  in  1  consumer accepts word
- rx_data  out  9  received word; bit 8 = control flag
- rx_overflow  out  1  sticky: a word arrived while rx_valid was high and not accepted
- rx_overflow_clr  in  1  clears rx_overflow
- tx_valid  in  1  producer offers byte
- tx_ready  out  1  TX FIFO not full
- tx_data  in  8  byte to send
- tx_level  out  TX_DEPTH_LOG2+1  TX FIFO occupancy

Behaviour:
- Reset values (asynchronous): all sync flops 0, rx_valid 0, rx_data 0, rx_overflow 0, raspi_dat_oe 0, raspi_dat_o 0, TX FIFO empty, tx_ready 1, tx_level 0, turnaround counter 0.
- Synchronization:
  - raspi_clk, raspi_dir and raspi_dat_i each pass through SYNC_STAGES flops.
  - Event = sync_clk high while the previous sync_clk was low.
  - Data and dir are taken from their synchronized copies in the event cycle. Host keeps data stable ≥ SYNC_STAGES+1 clk cycles before and after the strobe edge.
- RX, event with sync_dir=1:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data = sync_dat and set rx_valid=1 on the next edge.
  - Otherwise keep the old word and set rx_overflow.
  - Latency: pad strobe edge to rx_valid = SYNC_STAGES+1 clk cycles.
  - rx_valid clears on rx_ready when no event is loaded in that cycle.
  - rx_overflow_clr and an overflow in the same cycle: overflow wins.
- Bus direction / turnaround:
  - Counter increments while sync_dir=0, saturating at TURN_CYCLES.
  - raspi_dat_oe = 1 only when counter == TURN_CYCLES.
  - sync_dir=1 clears the counter and deasserts oe in that same cycle (combinational from sync_dir), so the FPGA never drives during a host write.
- TX:
  - raspi_dat_o = {1'b1, fifo_head} when FIFO non-empty, 9'h000 when empty. Bit 8 tells the host the byte is valid.
  - Event with sync_dir=0 and oe=1 pops one entry if non-empty. Pop on empty is ignored.
  - Events with dir=0 but oe=0 (inside turnaround) are dropped: no pop, no RX.
  - Push when tx_valid & tx_ready.
  - Push and pop in the same cycle: level unchanged, and allowed when full.
  - Pointers are TX_DEPTH_LOG2+1 bits and wrap naturally. Full = MSBs differ and LSBs are equal.
  - tx_ready = !full, registered from the pointer compare.
- Reset mid-transfer: FIFO contents discarded, rx word lost, oe drops immediately (asynchronous).

Decomposition:
- Shared package raspi_pkg:
  - RASPI_W = 9.
  - CTRL_START = 9'h101, CTRL_END = 9'h100.
  - TX_EMPTY_WORD = 9'h000.
- One sub-module, raspi_tx_fifo: synchronous FIFO with parameter depth, push/pop, full/empty/level.
- Synchronizers stay inline.

Test Plan:
- Reset released, dir=1, host sends 0x101 then 0x3C with rx_ready=1 → rx_data 0x101 then 0x03C, one rx_valid pulse each, exactly SYNC_STAGES+1 cycles after each strobe edge.
- rx_ready=0, host sends 0x11, 0x22 → rx_data stays 0x011, rx_overflow=1. Pulse rx_overflow_clr → flag 0.
- Push 0xA5, 0x5A; host sets dir=0 and waits → oe rises after TURN_CYCLES+SYNC_STAGES cycles, dat_o=0x1A5. Strobe → 0x15A; strobe → 0x000, tx_level 0.
- Push 16 bytes → tx_ready=0, tx_level=16. 17th push blocked. Simultaneous push and pop while full → level stays 16, data order preserved.
- dir toggles 0→1 while oe=1 → oe=0 in the cycle sync_dir=1. Strobe at dir=0 during turnaround → no pop.
- Full firmware-load sequence: 0x101, 1024 bytes, 0x100 with rx_ready=1 → the consumer sees 1026 words in order, with no overflow.
